// File: rtl/cache_miss_ctl.sv
// Miss sequencer between a CPU port, a direct-mapped cache bank and main memory.
// Define CACHE_MISS_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_miss_ctl #(
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int DATA_W  = 16,
  localparam int ADDR_W = TAG_W + INDEX_W + WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cache_en,
  output logic [INDEX_W-1:0] cache_index,
  output logic [WORD_W-1:0] cache_word,
  output logic              cache_cmp,
  output logic              cache_wr,
  output logic [TAG_W-1:0]  cache_tag_in,
  output logic [DATA_W-1:0] cache_data_in,
  output logic              cache_valid_in,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic              cache_valid,
  input  logic [TAG_W-1:0]  cache_tag_out,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef CACHE_MISS_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMP     = 3'd1,
    S_WB_RD   = 3'd2,
    S_WB_WR   = 3'd3,
    S_FILL_RD = 3'd4,
    S_FILL_WR = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t              r_state, w_next;
  logic                r_gap;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [TAG_W-1:0]    r_vtag;
  logic [DATA_W-1:0]   r_data;
  logic [WORD_W-1:0]   r_k;

  logic [TAG_W-1:0]    w_req_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [WORD_W-1:0]   w_word;
  logic                w_k_max;
  logic                w_cache_st, w_mem_st;
  logic                w_cache_fire, w_mem_fire;

  assign w_req_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_index   = r_addr[WORD_W +: INDEX_W];
  assign w_word    = r_addr[WORD_W-1:0];
  assign w_k_max   = (r_k == {WORD_W{1'b1}});

  // Handshake: a strobe (cache_en / mem_req) and its whole bundle stay stable
  // until the matching ack is sampled high; that edge completes the transfer and
  // captures the responder's outputs. r_gap then forces the strobe low for a cycle.
  assign w_cache_st   = (r_state == S_CMP) || (r_state == S_WB_RD) || (r_state == S_FILL_WR);
  assign w_mem_st     = (r_state == S_WB_WR) || (r_state == S_FILL_RD);
  assign cache_en     = w_cache_st && !r_gap;
  assign mem_req      = w_mem_st && !r_gap;
  assign w_cache_fire = cache_en && cache_ack;
  assign w_mem_fire   = mem_req && mem_ack;
  assign dbg_state    = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    cpu_busy       = (r_state != S_IDLE);
    cpu_ready      = 1'b0;
    cpu_rdata      = '0;
    cache_index    = '0;
    cache_word     = '0;
    cache_cmp      = 1'b0;
    cache_wr       = 1'b0;
    cache_tag_in   = '0;
    cache_data_in  = '0;
    cache_valid_in = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (r_state)
      S_IDLE: if (cpu_req) w_next = S_CMP;
      S_CMP: begin
        cache_index   = w_index;
        cache_word    = w_word;
        cache_cmp     = 1'b1;
        cache_wr      = r_wr;
        cache_tag_in  = w_req_tag;
        cache_data_in = r_wdata;
        if (w_cache_fire) begin
          if (cache_hit)                      w_next = S_DONE;
          else if (cache_valid && cache_dirty) w_next = S_WB_RD;
          else                                w_next = S_FILL_RD;
        end
      end
      S_WB_RD: begin
        cache_index = w_index;
        cache_word  = r_k;
        if (w_cache_fire) w_next = S_WB_WR;
      end
      S_WB_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = {r_vtag, w_index, r_k};
        mem_wdata = r_data;
        if (w_mem_fire) w_next = w_k_max ? S_FILL_RD : S_WB_RD;
      end
      S_FILL_RD: begin
        mem_addr = {w_req_tag, w_index, r_k};
        if (w_mem_fire) w_next = S_FILL_WR;
      end
      S_FILL_WR: begin
        cache_index    = w_index;
        cache_word     = r_k;
        cache_wr       = 1'b1;
        cache_tag_in   = w_req_tag;
        cache_data_in  = r_data;
        cache_valid_in = 1'b1;
        if (w_cache_fire) w_next = w_k_max ? S_CMP : S_FILL_RD;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = r_wr ? '0 : r_data;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_k wraps to 0 on its own after the last word of a line transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_vtag  <= '0;
      r_data  <= '0;
      r_k     <= '0;
    end else begin
      r_gap <= w_cache_fire || w_mem_fire;
      case (r_state)
        S_IDLE: if (cpu_req) begin
          r_wr    <= cpu_wr;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
        S_CMP: if (w_cache_fire) begin
          r_data <= cache_data_out;
          if (!cache_hit) begin
            r_vtag <= cache_tag_out;
            r_k    <= '0;
          end
        end
        S_WB_RD:   if (w_cache_fire) r_data <= cache_data_out;
        S_WB_WR:   if (w_mem_fire)   r_k <= r_k + 1'b1;
        S_FILL_RD: if (w_mem_fire)   r_data <= mem_rdata;
        S_FILL_WR: if (w_cache_fire) r_k <= r_k + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_MISS_STATS_EN
  logic        r_retry;
  logic [15:0] r_hit_cnt, r_miss_cnt;

  // Only the first compare of a request is counted; retries after a fill are not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retry    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && cpu_req) r_retry <= 1'b0;
      if (r_state == S_CMP && w_cache_fire) begin
        if (!cache_hit) r_retry <= 1'b1;
        if (!r_retry) begin
          if (cache_hit && r_hit_cnt != 16'hFFFF)    r_hit_cnt  <= r_hit_cnt + 16'd1;
          if (!cache_hit && r_miss_cnt != 16'hFFFF)  r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
